wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/tcore_param.sv | 17 +
 rtl/wb_result_buf.sv | 43 ++++
 rtl/wb_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tcore_param.sv
// Shared core parameters: register width, writeback arbiter states and starvation limit.
// Latency: none (definitions only).
// Backpressure: n/a.
package tcore_param;

    localparam int XLEN         = 32;
    localparam int STARVE_LIMIT = 8;

    // Writeback arbiter states: EMPTY (no buffered result), FULL (result
    // waiting for a free port), FORCE (port taken from the pipeline to drain).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        FORCE = 2'd2
    } wb_arb_state_e;

endpackage

// File: rtl/wb_result_buf.sv
// One-entry holding buffer for a multi-cycle unit result (rd, data).
// Latency: loaded entry is visible on out_* the cycle after in_vld && in_rdy.
// Backpressure: in_rdy is low while the entry is held; out_pop frees it.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   in_vld/in_rdy        load handshake, in_rd/in_dat are the loaded entry
//   out_vld/out_rd/dat   held entry
//   out_pop              release the held entry (write, cancel or discard)
module wb_result_buf
    import tcore_param::*;
#(
    parameter int W = XLEN
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [4:0]   in_rd,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    output logic [4:0]   out_rd,
    output logic [W-1:0] out_dat,
    input  logic         out_pop
);

    assign in_rdy = !out_vld;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_vld <= 1'b0;
            out_rd  <= 5'd0;
            out_dat <= '0;
        end else if (in_vld && in_rdy) begin
            out_vld <= 1'b1;
            out_rd  <= in_rd;
            out_dat <= in_dat;
        end else if (out_pop) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and a buffered multi-cycle result.
// Latency: buffered result written >= 1 cycle after accept; pipeline writes pass through combinationally.
// Backpressure: div_ready_o only when the buffer is empty; pipe_stall_o during a forced drain.
//
// Optional starvation guard: define WB_ARB_STARVE_GUARD_EN to force a drain
// after STARVE_LIMIT-1 blocked cycles; otherwise the pipeline always wins.
//
// Ports:
//   clk_i, rst_i                          clock, asynchronous active-high reset
//   pipe_we_i/pipe_rd_i/pipe_data_i       pipeline writeback request
//   trap_active_i                         trap in writeback, suppresses the pipeline write
//   div_valid_i/div_rd_i/div_data_i       multi-cycle result offer, div_ready_o accepts it
//   rf_we_o/rf_rd_o/rf_data_o             register-file write port
//   pipe_stall_o                          stall request while the buffer is forced out
module wb_port_arbiter
    import tcore_param::*;
#(
    parameter int XLEN         = tcore_param::XLEN,
    parameter int STARVE_LIMIT = tcore_param::STARVE_LIMIT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pipe_we_i,
    input  logic [4:0]      pipe_rd_i,
    input  logic [XLEN-1:0] pipe_data_i,
    input  logic            trap_active_i,
    input  logic            div_valid_i,
    input  logic [4:0]      div_rd_i,
    input  logic [XLEN-1:0] div_data_i,
    output logic            div_ready_o,
    output logic            rf_we_o,
    output logic [4:0]      rf_rd_o,
    output logic [XLEN-1:0] rf_data_o,
    output logic            pipe_stall_o
);

    // The forced drain needs at least one blocked cycle before it fires.
    if (STARVE_LIMIT < 2) begin : g_bad_limit
        $error("wb_port_arbiter: STARVE_LIMIT must be at least 2");
    end

    wb_arb_state_e state;

    logic            buf_in_rdy;
    logic            buf_vld;
    logic [4:0]      buf_rd;
    logic [XLEN-1:0] buf_dat;
    logic            buf_pop;

    logic pipe_wr;      // pipeline actually wants the port this cycle
    logic buf_zero;     // buffered entry targets x0 and is simply dropped
    logic buf_hit;      // younger pipeline write to the same rd supersedes the buffer
    logic blocked;      // buffer held back by the pipeline this cycle

    assign pipe_wr  = pipe_we_i && !trap_active_i;
    assign buf_zero = (buf_rd == 5'd0);
    assign buf_hit  = pipe_wr && (pipe_rd_i == buf_rd);
    assign blocked  = (state == FULL) && buf_vld && pipe_wr && !buf_hit && !buf_zero;
    assign buf_pop  = ((state == FULL) && !blocked) || (state == FORCE);

    wb_result_buf #(.W(XLEN)) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .in_vld  (div_valid_i && (state == EMPTY)),
        .in_rdy  (buf_in_rdy),
        .in_rd   (div_rd_i),
        .in_dat  (div_data_i),
        .out_vld (buf_vld),
        .out_rd  (buf_rd),
        .out_dat (buf_dat),
        .out_pop (buf_pop)
    );

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_cnt_nxt;

    assign starve_cnt_nxt = starve_cnt + 1'b1;
`endif

    // Arbitration FSM. Every path out of FULL except a blocked cycle empties the buffer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= EMPTY;
`ifdef WB_ARB_STARVE_GUARD_EN
            starve_cnt <= '0;
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (div_valid_i && buf_in_rdy) begin
                        state <= FULL;
                    end
`ifdef WB_ARB_STARVE_GUARD_EN
                    starve_cnt <= '0;
`endif
                end
                FULL: begin
                    if (blocked) begin
`ifdef WB_ARB_STARVE_GUARD_EN
                        starve_cnt <= starve_cnt_nxt;
                        if (starve_cnt_nxt == CW'(STARVE_LIMIT - 1)) begin
                            state <= FORCE;
                        end
`endif
                    end else begin
                        state <= EMPTY;
`ifdef WB_ARB_STARVE_GUARD_EN
                        starve_cnt <= '0;
`endif
                    end
                end
                default: begin
                    state <= EMPTY;
`ifdef WB_ARB_STARVE_GUARD_EN
                    starve_cnt <= '0;
`endif
                end
            endcase
        end
    end

    // Write port mux. Reset gates everything so no write escapes while rst_i is high.
    always_comb begin
        div_ready_o  = 1'b0;
        rf_we_o      = 1'b0;
        rf_rd_o      = 5'd0;
        rf_data_o    = '0;
        pipe_stall_o = 1'b0;
        if (!rst_i) begin
            div_ready_o = (state == EMPTY) && buf_in_rdy;
`ifdef WB_ARB_STARVE_GUARD_EN
            if (state == FORCE) begin
                pipe_stall_o = 1'b1;
                rf_we_o      = 1'b1;
                rf_rd_o      = buf_rd;
                rf_data_o    = buf_dat;
            end else
`endif
            if (pipe_wr) begin
                if (pipe_rd_i != 5'd0) begin
                    rf_we_o   = 1'b1;
                    rf_rd_o   = pipe_rd_i;
                    rf_data_o = pipe_data_i;
                end
            end else if ((state == FULL) && buf_vld && !buf_zero) begin
                rf_we_o   = 1'b1;
                rf_rd_o   = buf_rd;
                rf_data_o = buf_dat;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int SL = 8;
`ifdef WB_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pipe_we_i;
    logic [4:0]  pipe_rd_i;
    logic [31:0] pipe_data_i;
    logic        trap_active_i;
    logic        div_valid_i;
    logic [4:0]  div_rd_i;
    logic [31:0] div_data_i;
    logic        div_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_data_o;
    logic        pipe_stall_o;

    wb_port_arbiter #(.XLEN(32), .STARVE_LIMIT(SL)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pipe_we_i     (pipe_we_i),
        .pipe_rd_i     (pipe_rd_i),
        .pipe_data_i   (pipe_data_i),
        .trap_active_i (trap_active_i),
        .div_valid_i   (div_valid_i),
        .div_rd_i      (div_rd_i),
        .div_data_i    (div_data_i),
        .div_ready_o   (div_ready_o),
        .rf_we_o       (rf_we_o),
        .rf_rd_o       (rf_rd_o),
        .rf_data_o     (rf_data_o),
        .pipe_stall_o  (pipe_stall_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic        pwe;
        logic [4:0]  prd;
        logic [31:0] pdat;
        logic        trap;
        logic        dvld;
        logic [4:0]  drd;
        logic [31:0] ddat;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_dat;
        logic        e_rdy;
        logic        e_stall;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(logic rst, logic pwe, logic [4:0] prd, logic [31:0] pdat,
                                logic trap, logic dvld, logic [4:0] drd, logic [31:0] ddat,
                                logic e_we, logic [4:0] e_rd, logic [31:0] e_dat,
                                logic e_rdy, logic e_stall);
        vec_t v;
        v.rst = rst; v.pwe = pwe; v.prd = prd; v.pdat = pdat; v.trap = trap;
        v.dvld = dvld; v.drd = drd; v.ddat = ddat;
        v.e_we = e_we; v.e_rd = e_rd; v.e_dat = e_dat; v.e_rdy = e_rdy; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic pwe, input logic [4:0] prd,
                         input logic [31:0] pdat, input logic trap, input logic dvld,
                         input logic [4:0] drd, input logic [31:0] ddat);
        rst_i         = rst;
        pipe_we_i     = pwe;
        pipe_rd_i     = prd;
        pipe_data_i   = pdat;
        trap_active_i = trap;
        div_valid_i   = dvld;
        div_rd_i      = drd;
        div_data_i    = ddat;
    endtask

    task automatic check(input string name, input logic e_we, input logic [4:0] e_rd,
                         input logic [31:0] e_dat, input logic e_rdy, input logic e_stall);
        n_checks++;
        if (rf_we_o !== e_we || rf_rd_o !== e_rd || rf_data_o !== e_dat ||
            div_ready_o !== e_rdy || pipe_stall_o !== e_stall) begin
            n_fail++;
            $display("FAIL %s: got we=%0b rd=%0d data=%h rdy=%0b stall=%0b, want we=%0b rd=%0d data=%h rdy=%0b stall=%0b",
                     name, rf_we_o, rf_rd_o, rf_data_o, div_ready_o, pipe_stall_o,
                     e_we, e_rd, e_dat, e_rdy, e_stall);
        end
    endtask

    // Reference model: a queue of at most one pending result plus the number
    // of cycles it has been kept off the port.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t pend[$];
    int   waited = 0;
    bit   drain_now = 1'b0;

    task automatic model_step(output logic e_we, output logic [4:0] e_rd, output logic [31:0] e_dat,
                              output logic e_rdy, output logic e_stall);
        bit owns;
        e_we = 1'b0; e_rd = 5'd0; e_dat = 32'd0; e_rdy = 1'b0; e_stall = 1'b0;
        if (rst_i) begin
            pend.delete();
            waited = 0;
            drain_now = 1'b0;
            return;
        end
        owns  = pipe_we_i && !trap_active_i;
        e_rdy = (pend.size() == 0);
        if (drain_now) begin
            e_stall = 1'b1;
            e_we = 1'b1; e_rd = pend[0].rd; e_dat = pend[0].data;
            pend.delete();
            waited = 0;
            drain_now = 1'b0;
        end else begin
            if (owns && pipe_rd_i != 5'd0) begin
                e_we = 1'b1; e_rd = pipe_rd_i; e_dat = pipe_data_i;
            end
            if (pend.size() == 0) begin
                if (div_valid_i) pend.push_back('{div_rd_i, div_data_i});
            end else if (pend[0].rd == 5'd0) begin
                pend.delete();
                waited = 0;
            end else if (owns && pipe_rd_i == pend[0].rd) begin
                pend.delete();
                waited = 0;
            end else if (owns) begin
                waited++;
                if (GUARD && waited == SL - 1) drain_now = 1'b1;
            end else begin
                e_we = 1'b1; e_rd = pend[0].rd; e_dat = pend[0].data;
                pend.delete();
                waited = 0;
            end
        end
    endtask

    initial begin
        logic        m_we, m_rdy, m_stall;
        logic [4:0]  m_rd;
        logic [31:0] m_dat;

        tbl[0]  = mk(0, 0, 0, 0,        0, 1, 5,  32'hA5A5A5A5, 0, 0, 0,            1, 0);
        tbl[1]  = mk(0, 0, 0, 0,        0, 0, 0,  0,            1, 5, 32'hA5A5A5A5, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0,        0, 0, 0,  0,            0, 0, 0,            1, 0);
        tbl[3]  = mk(0, 0, 0, 0,        0, 1, 7,  32'h77,       0, 0, 0,            1, 0);
        tbl[4]  = mk(0, 1, 3, 32'h31,   0, 0, 0,  0,            1, 3, 32'h31,       0, 0);
        tbl[5]  = mk(0, 1, 3, 32'h32,   0, 0, 0,  0,            1, 3, 32'h32,       0, 0);
        tbl[6]  = mk(0, 1, 3, 32'h33,   0, 0, 0,  0,            1, 3, 32'h33,       0, 0);
        tbl[7]  = mk(0, 0, 0, 0,        0, 0, 0,  0,            1, 7, 32'h77,       0, 0);
        tbl[8]  = mk(0, 0, 0, 0,        0, 0, 0,  0,            0, 0, 0,            1, 0);
        tbl[9]  = mk(0, 0, 0, 0,        0, 1, 9,  32'h99,       0, 0, 0,            1, 0);
        tbl[10] = mk(0, 1, 9, 32'h1234, 0, 0, 0,  0,            1, 9, 32'h1234,     0, 0);
        tbl[11] = mk(0, 0, 0, 0,        0, 0, 0,  0,            0, 0, 0,            1, 0);
        tbl[12] = mk(0, 0, 0, 0,        0, 0, 0,  0,            0, 0, 0,            1, 0);
        tbl[13] = mk(0, 0, 0, 0,        0, 1, 11, 32'hBB,       0, 0, 0,            1, 0);
        tbl[14] = mk(0, 1, 4, 32'h44,   1, 0, 0,  0,            1, 11, 32'hBB,      0, 0);
        tbl[15] = mk(0, 1, 4, 32'h44,   1, 0, 0,  0,            0, 0, 0,            1, 0);
        tbl[16] = mk(0, 0, 0, 0,        0, 1, 0,  32'hDEAD,     0, 0, 0,            1, 0);
        tbl[17] = mk(0, 0, 0, 0,        0, 0, 0,  0,            0, 0, 0,            0, 0);
        tbl[18] = mk(0, 0, 0, 0,        0, 0, 0,  0,            0, 0, 0,            1, 0);
        tbl[19] = mk(0, 1, 0, 32'h5,    0, 0, 0,  0,            0, 0, 0,            1, 0);
        tbl[20] = mk(0, 0, 0, 0,        0, 1, 12, 32'hCC,       0, 0, 0,            1, 0);
        tbl[21] = mk(1, 1, 6, 32'h66,   0, 0, 0,  0,            0, 0, 0,            0, 0);
        tbl[22] = mk(0, 0, 0, 0,        0, 0, 0,  0,            0, 0, 0,            1, 0);
        tbl[23] = mk(0, 0, 0, 0,        0, 0, 0,  0,            0, 0, 0,            1, 0);

        // Reset state, with live requests on the inputs that must be ignored.
        drive(1, 1, 5'd1, 32'h1111, 0, 1, 5'd2, 32'h2222);
        repeat (2) @(negedge clk_i);
        #1;
        check("reset_state", 0, 0, 0, 0, 0);
        @(negedge clk_i);

        // Directed table; vector 0 is the first cycle after reset release.
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].rst, tbl[i].pwe, tbl[i].prd, tbl[i].pdat,
                  tbl[i].trap, tbl[i].dvld, tbl[i].drd, tbl[i].ddat);
            #1;
            check($sformatf("vec[%0d]", i), tbl[i].e_we, tbl[i].e_rd, tbl[i].e_dat,
                  tbl[i].e_rdy, tbl[i].e_stall);
            @(negedge clk_i);
        end

        // Starvation: buffer rd=13 held back by a continuous pipeline write to rd=2.
        drive(0, 0, 5'd0, 32'd0, 0, 1, 5'd13, 32'hF0F0F0F0);
        #1;
        check("starve_accept", 0, 0, 0, 1, 0);
        @(negedge clk_i);
        for (int k = 1; k <= 12; k++) begin
            drive(0, 1, 5'd2, 32'(k), 0, 0, 5'd0, 32'd0);
            #1;
            if (GUARD && k == SL)
                check($sformatf("starve_cyc%0d", k), 1, 5'd13, 32'hF0F0F0F0, 0, 1);
            else
                check($sformatf("starve_cyc%0d", k), 1, 5'd2, 32'(k), (GUARD && k > SL), 0);
            @(negedge clk_i);
        end
        drive(0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        #1;
        if (GUARD) check("starve_release", 0, 0, 0, 1, 0);
        else       check("starve_release", 1, 5'd13, 32'hF0F0F0F0, 0, 0);
        @(negedge clk_i);
        #1;
        check("starve_idle", 0, 0, 0, 1, 0);
        @(negedge clk_i);

        // Randomized traffic against the queue model; starts with a reset cycle.
        for (int c = 0; c < 3000; c++) begin
            drive((c == 0) || ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 6),
                  5'($urandom_range(0, 7)),
                  $urandom,
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 7)),
                  $urandom);
            #1;
            model_step(m_we, m_rd, m_dat, m_rdy, m_stall);
            check($sformatf("rand[%0d]", c), m_we, m_rd, m_dat, m_rdy, m_stall);
            @(negedge clk_i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
